// File: rtl/spi_reg_slave.sv
// SPI responder for 16-bit {addr[6:0], data[8:0]} frames, oversampled in clk.
// Good frames land in a small register file exposed through a registered read port.
module spi_reg_slave #(
  parameter int NUM_REGS   = 16,
  parameter bit SYNC_EN    = 1'b0,
  parameter int RESET_ADDR = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic [6:0] rx_addr,
  output logic [8:0] rx_data,
  output logic       frame_valid,
  output logic       frame_err,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Input stage: first flop always, second only used when SYNC_EN is set.
  logic sclk_s1_q, mosi_s1_q, cs_s1_q;
  logic sclk_s2_q, mosi_s2_q, cs_s2_q;
  logic sclk_q, cs_q;
  logic sclk_i, mosi_i, cs_i;
  logic sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      cs_s1_q   <= 1'b0;
      sclk_s2_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s2_q   <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      mosi_s1_q <= mosi;
      cs_s1_q   <= cs_n;
      sclk_s2_q <= sclk_s1_q;
      mosi_s2_q <= mosi_s1_q;
      cs_s2_q   <= cs_s1_q;
      sclk_q    <= sclk_i;
      cs_q      <= cs_i;
    end
  end

  assign sclk_i    = SYNC_EN ? sclk_s2_q : sclk_s1_q;
  assign mosi_i    = SYNC_EN ? mosi_s2_q : mosi_s1_q;
  assign cs_i      = SYNC_EN ? cs_s2_q   : cs_s1_q;
  assign sclk_rise = sclk_i & ~sclk_q;
  assign cs_fall   = ~cs_i & cs_q;
  assign cs_rise   = cs_i & ~cs_q;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  rx_addr_q, rx_addr_d;
  logic [8:0]  rx_data_q, rx_data_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [8:0]  rd_data_q, rd_data_d;
  logic [8:0]  regs_q [NUM_REGS];
  logic [8:0]  regs_d [NUM_REGS];
  logic        frame_good;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    rx_addr_d     = rx_addr_q;
    rx_data_d     = rx_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    regs_d        = regs_q;
    frame_good    = (cnt_q == 5'd16) && (int'(shift_q[15:9]) < NUM_REGS);
    rd_data_d     = (int'(rd_addr) < NUM_REGS) ? regs_q[rd_addr] : '0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The verdict is registered on the way into CHECK so the pulse is high during CHECK.
        if (cs_rise) begin
          state_d       = CHECK;
          frame_valid_d = frame_good;
          frame_err_d   = ~frame_good;
          if (frame_good) begin
            rx_addr_d = shift_q[15:9];
            rx_data_d = shift_q[8:0];
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], mosi_i};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_valid_q) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rx_addr_q) == RESET_ADDR) regs_d[i] = '0;
            else if (int'(rx_addr_q) == i)     regs_d[i] = rx_data_q;
          end
        end
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      rx_addr_q     <= '0;
      rx_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      rd_data_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      rx_addr_q     <= rx_addr_d;
      rx_data_q     <= rx_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      rd_data_q     <= rd_data_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rx_addr     = rx_addr_q;
  assign rx_data     = rx_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign rd_data     = rd_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed frames plus random traffic, checked against a
// frame-level model of the register file and the rx_* holding registers.
module tb_spi_reg_slave;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, cs_n;
  logic [6:0] rx_addr;
  logic [8:0] rx_data;
  logic       frame_valid, frame_err;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  spi_reg_slave #(.NUM_REGS(16), .SYNC_EN(1'b0), .RESET_ADDR(15)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .rx_addr(rx_addr), .rx_data(rx_data), .frame_valid(frame_valid),
    .frame_err(frame_err), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Expected pulse outcomes: {is_err, rx_addr, rx_data}.
  logic [16:0] exp_q[$];
  logic [8:0]  m_regs [16];
  logic [6:0]  m_rx_addr;
  logic [8:0]  m_rx_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_rx_addr = '0;
    m_rx_data = '0;
  endtask

  task automatic model_frame(input logic [31:0] bits, input int nbits);
    logic [6:0] a;
    logic [8:0] d;
    logic       ok;
    a  = bits[15:9];
    d  = bits[8:0];
    ok = (nbits == 16) && (a < 7'd16);
    if (ok) begin
      m_rx_addr = a;
      m_rx_data = d;
      if (a == 7'd15) foreach (m_regs[i]) m_regs[i] = '0;
      else m_regs[a[3:0]] = d;
    end
    exp_q.push_back({~ok, m_rx_addr, m_rx_data});
  endtask

  // Master: sclk idles high, mosi changes on the falling edge, sclk = clk/4.
  task automatic send_bits(input logic [31:0] bits, input int nbits, input int gap);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = bits[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_frame(input logic [31:0] bits, input int nbits, input int gap);
    model_frame(bits, nbits);
    send_bits(bits, nbits, gap);
  endtask

  task automatic wait_drained(input int n);
    repeat (n) @(negedge clk);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(m_regs[a]));
    end
  endtask

  // Pulse monitor: one pulse per frame, exclusive, one cycle wide, matching the model.
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (prev_pulse) chk("pulse_width", 32'(frame_valid | frame_err), 32'd0);
      if (frame_valid | frame_err) begin
        pulses++;
        chk("exclusive", 32'(frame_valid & frame_err), 32'd0);
        chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_result", 32'({frame_err, rx_addr, rx_data}), 32'(e));
        end
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          nb;
    int          pulses_before;
    logic [31:0] bits;
    logic [6:0]  a;
    logic [14:0] data_tx;

    rst = 1'b0; sclk = 1'b1; mosi = 1'b0; cs_n = 1'b1; rd_addr = '0;
    model_reset();

    // Reset held: inputs toggle, outputs stay 0.
    repeat (16) begin
      @(negedge clk);
      sclk = 1'($urandom); mosi = 1'($urandom); cs_n = 1'($urandom);
      rd_addr = 4'($urandom_range(0, 15));
      #1;
      chk("reset_outputs", 32'({rx_addr, rx_data, frame_valid, frame_err, rd_data}), 32'd0);
    end
    @(negedge clk);
    sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sweep("after_reset");

    // Single good frame: latency, contents, read-during-write ordering.
    rd_addr = 4'd9;
    @(negedge clk);
    do_frame(32'h1234, 16, 0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (frame_valid | frame_err) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("valid_pulse", 32'(frame_valid), 32'd1);
    chk("rx_addr_1234", 32'(rx_addr), 32'h09);
    chk("rx_data_1234", 32'(rx_data), 32'h034);
    @(negedge clk);
    chk("rd_old_value", 32'(rd_data), 32'h000);
    @(negedge clk);
    chk("rd_new_value", 32'(rd_data), 32'h034);
    wait_drained(6);
    sweep("frame_1234");

    // Short and saturated-long frames are discarded.
    do_frame(32'($urandom_range(0, 4095)), 12, 3);
    do_frame(32'($urandom_range(0, 1048575)), 20, 3);
    wait_drained(8);
    chk("rx_addr_kept", 32'(rx_addr), 32'h09);
    chk("rx_data_kept", 32'(rx_data), 32'h034);
    sweep("bad_len");

    // Out-of-range address, then the clear-all address.
    do_frame(32'h0000_0603, 16, 3);
    do_frame(32'h0000_0E1F, 16, 3);
    do_frame(32'h4000 | 32'($urandom_range(0, 511)), 16, 3);
    wait_drained(8);
    sweep("pre_clear");
    do_frame(32'h1E00, 16, 3);
    wait_drained(8);
    chk("rx_addr_clear", 32'(rx_addr), 32'h0F);
    sweep("cleared");

    // Back-to-back frames with cs_n high for one cycle.
    do_frame(32'h0201, 16, 1);
    do_frame(32'h0403, 16, 2);
    wait_drained(8);
    rd_addr = 4'd1;
    @(negedge clk);
    chk("b2b_reg1", 32'(rd_data), 32'h001);
    rd_addr = 4'd2;
    @(negedge clk);
    chk("b2b_reg2", 32'(rd_data), 32'h003);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(8, 20);
      else nb = 16;
      if (nb == 16) begin
        if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(16, 127));
        else a = 7'($urandom_range(0, 15));
        bits = 32'({a, 9'($urandom_range(0, 511))});
      end else begin
        bits = $urandom & ((32'd1 << nb) - 32'd1);
      end
      do_frame(bits, nb, $urandom_range(1, 4));
    end
    wait_drained(10);
    sweep("random");

    // spi_wr framing: addr field, a zero bit, then the low data byte.
    data_tx = 15'h0A55;
    do_frame(32'({data_tx[14:8], 1'b0, data_tx[7:0]}), 16, 3);
    wait_drained(8);
    chk("spi_wr_addr", 32'(rx_addr), 32'h0A);
    chk("spi_wr_data", 32'(rx_data), 32'h055);

    // Reset in the middle of a frame: no pulse, everything cleared.
    pulses_before = pulses;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; mosi = 1'($urandom);
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    chk("no_pulse_on_reset", 32'(pulses), 32'(pulses_before));
    chk("rx_after_reset", 32'({rx_addr, rx_data}), 32'd0);
    sweep("mid_reset");
    do_frame(32'h0A77, 16, 3);
    wait_drained(8);
    sweep("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
